fifo_rr_drain: RTL and testbench

//  Downstream consumer of the per-input-port FIFOs of a router output channel.

---
 rtl/fifo_rr_drain.sv | 132 +++++++++++++
 tb/tb_fifo_rr_drain.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of PORTS input FIFOs into one registered valid/ready output slot,
// tagging each item with the index of the FIFO it came from.
//
//   state    | meaning
//   S_IDLE   | output slot empty, out_valid low
//   S_LOADED | output slot holds an item, out_valid high until the link accepts it
module fifo_rr_drain #(
   parameter int ID               = -1,
   parameter int SIZE             = 8,
   parameter int DESTINATION_BITS = 4,
   parameter int PORTS            = 4,
   parameter int PORT_BITS        = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [PORTS-1:0]            empty,
   input  logic [PORTS*SIZE-1:0]       item_in,
   output logic [PORTS-1:0]            read,
   output logic [SIZE-1:0]             out_item,
   output logic [PORT_BITS-1:0]        out_port,
   output logic [DESTINATION_BITS-1:0] out_dest,
   output logic                        out_valid,
   input  logic                        out_ready
);

   localparam int NSLOT = 2**PORT_BITS;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_LOADED = 1'b1
   } state_t;

   state_t                 state_q;
   logic [SIZE-1:0]        item_q;
   logic [PORT_BITS-1:0]   port_q;
   logic [PORT_BITS-1:0]   rr_ptr_q;
   logic [PORT_BITS-1:0]   rr_ptr_d;

   logic [NSLOT-1:0]       empty_ext;
   logic [SIZE-1:0]        items [NSLOT];
   logic [PORT_BITS:0]     cand;
   logic [PORT_BITS-1:0]   grant;
   logic                   any;
   logic                   can_load;
   logic                   load;

   // Pad the per-port views out to the full index range so any grant value indexes cleanly.
   assign empty_ext = NSLOT'(empty);

   for (genvar g = 0; g < NSLOT; g++) begin : g_items
      if (g < PORTS) begin : g_real
         assign items[g] = item_in[g*SIZE +: SIZE];
      end else begin : g_pad
         assign items[g] = '0;
      end
   end

   // Search starts at rr_ptr and wraps at PORTS-1; one extra bit keeps the sum from overflowing.
   always_comb begin
      any   = 1'b0;
      grant = '0;
      cand  = '0;
      for (int k = 0; k < PORTS; k++) begin
         cand = {1'b0, rr_ptr_q} + (PORT_BITS+1)'(k);
         if (cand >= (PORT_BITS+1)'(PORTS)) begin
            cand = cand - (PORT_BITS+1)'(PORTS);
         end
         if (!any && !empty_ext[cand[PORT_BITS-1:0]]) begin
            any   = 1'b1;
            grant = cand[PORT_BITS-1:0];
         end
      end
   end

   assign rr_ptr_d = (grant == PORT_BITS'(PORTS-1)) ? '0 : grant + PORT_BITS'(1);
   assign can_load = (state_q == S_IDLE) || out_ready;
   assign load     = reset && can_load && any;

   always_comb begin
      read = '0;
      for (int p = 0; p < PORTS; p++) begin
         if (load && (grant == PORT_BITS'(p))) begin
            read[p] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         item_q   <= '0;
         port_q   <= '0;
         rr_ptr_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (any) begin
                  state_q  <= S_LOADED;
                  item_q   <= items[grant];
                  port_q   <= grant;
                  rr_ptr_q <= rr_ptr_d;
               end
            end
            S_LOADED: begin
               if (out_ready) begin
                  if (any) begin
                     item_q   <= items[grant];
                     port_q   <= grant;
                     rr_ptr_q <= rr_ptr_d;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out_valid = (state_q == S_LOADED);
   assign out_item  = item_q;
   assign out_port  = port_q;
   assign out_dest  = item_q[DESTINATION_BITS-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         assert ((read & empty) == '0)
            else $error("DRAIN%0d: pop strobe to an empty FIFO", ID);
      end
   end

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Bench for fifo_rr_drain: queue-based FIFO/arbiter model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic on a 4-port and a 3-port instance.
module tb_fifo_rr_drain;

   logic        clk = 1'b0;
   logic        reset;
   logic        out_ready;
   logic [3:0]  empty;
   logic [31:0] item_in;

   logic [3:0]  read4;
   logic [7:0]  item4;
   logic [3:0]  port4;
   logic [3:0]  dest4;
   logic        valid4;

   logic [2:0]  read3;
   logic [7:0]  item3;
   logic [1:0]  port3;
   logic [3:0]  dest3;
   logic        valid3;

   always #5 clk = ~clk;

   fifo_rr_drain #(.ID(0), .SIZE(8), .DESTINATION_BITS(4), .PORTS(4), .PORT_BITS(4)) u_dut4 (
      .clk(clk), .reset(reset), .empty(empty), .item_in(item_in), .read(read4),
      .out_item(item4), .out_port(port4), .out_dest(dest4), .out_valid(valid4),
      .out_ready(out_ready)
   );

   fifo_rr_drain #(.ID(1), .SIZE(8), .DESTINATION_BITS(4), .PORTS(3), .PORT_BITS(2)) u_dut3 (
      .clk(clk), .reset(reset), .empty(empty[2:0]), .item_in(item_in[23:0]), .read(read3),
      .out_item(item3), .out_port(port3), .out_dest(dest3), .out_valid(valid3),
      .out_ready(out_ready)
   );

   int          sel;
   logic [7:0]  fq [4][$];
   bit          m_valid;
   logic [7:0]  m_item;
   int          m_port;
   int          m_ptr;
   int          n_tests;
   int          n_fail;
   logic [3:0]  last_read;
   bit          verbose;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_fifos();
      for (int i = 0; i < 4; i++) begin
         empty[i] = (fq[i].size() == 0);
         item_in[i*8 +: 8] = empty[i] ? 8'($urandom) : fq[i][0];
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_item  = 8'h00;
      m_port  = 0;
      m_ptr   = 0;
   endtask

   // One cycle: compare DUT against the model, then advance the model across the clock edge.
   task automatic tick();
      int         grant;
      bit         any;
      bit         can_load;
      logic [3:0] exp_read;
      logic [3:0] a_read;
      logic       a_valid;
      logic [7:0] a_item;
      logic [3:0] a_port;
      logic [3:0] a_dest;
      drive_fifos();
      #1;
      if (sel == 4) begin
         a_read = read4; a_valid = valid4; a_item = item4; a_port = port4; a_dest = dest4;
      end else begin
         a_read = {1'b0, read3}; a_valid = valid3; a_item = item3;
         a_port = {2'b00, port3}; a_dest = dest3;
      end
      can_load = !m_valid || out_ready;
      any   = 1'b0;
      grant = 0;
      for (int k = 0; k < sel; k++) begin
         int idx = (m_ptr + k) % sel;
         if (!any && fq[idx].size() != 0) begin
            any   = 1'b1;
            grant = idx;
         end
      end
      exp_read = (reset && can_load && any) ? 4'(1 << grant) : 4'b0000;
      chk("read", 32'(a_read), 32'(exp_read));
      chk("out_valid", 32'(a_valid), 32'(m_valid));
      chk("out_item", 32'(a_item), 32'(m_item));
      chk("out_port", 32'(a_port), 32'(m_port));
      chk("out_dest", 32'(a_dest), 32'(m_item[3:0]));
      last_read = a_read;
      if (verbose && reset && m_valid && out_ready) begin
         $display("DRAIN%0d: %0d -> %0d", (sel == 4) ? 0 : 1, m_port, m_item[3:0]);
      end
      @(posedge clk);
      if (!reset) begin
         model_reset();
      end else if (can_load) begin
         if (any) begin
            m_item  = fq[grant].pop_front();
            m_port  = grant;
            m_valid = 1'b1;
            m_ptr   = (grant + 1) % sel;
         end else begin
            m_valid = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   // Unchecked reset of both instances, used when switching which one the model follows.
   task automatic flush();
      for (int i = 0; i < 4; i++) fq[i].delete();
      reset = 1'b0;
      drive_fifos();
      @(posedge clk);
      @(negedge clk);
      model_reset();
      reset = 1'b1;
   endtask

   task automatic push(input int p, input logic [7:0] v);
      fq[p].push_back(v);
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      verbose   = 1'b1;
      sel       = 4;
      reset     = 1'b0;
      out_ready = 1'b1;
      empty     = 4'hF;
      item_in   = '0;
      model_reset();
      for (int i = 0; i < 4; i++) push(i, 8'(8'h10 * (i + 1) + i));
      drive_fifos();
      @(posedge clk);
      @(negedge clk);

      // reset held with every FIFO non-empty: no pops, outputs cleared
      repeat (2) begin
         tick();
         chk("t1_read_in_reset", 32'(last_read), 32'h0);
         chk("t1_valid_in_reset", 32'(valid4), 32'h0);
      end
      reset = 1'b1;

      // continuous traffic, rr_ptr starts at 0 after release
      for (int n = 0; n < 8; n++) begin
         for (int i = 0; i < 4; i++) if (fq[i].size() < 2) push(i, 8'($urandom));
         tick();
         chk("t3_grant", 32'(last_read), 32'(1 << (n % 4)));
         chk("t3_port", 32'(port4), 32'(n % 4));
      end

      // single source
      flush();
      push(2, 8'h35);
      out_ready = 1'b1;
      tick();
      chk("t2_read", 32'(last_read), 32'h4);
      chk("t2_valid", 32'(valid4), 32'h1);
      chk("t2_item", 32'(item4), 32'h35);
      chk("t2_port", 32'(port4), 32'h2);
      chk("t2_dest", 32'(dest4), 32'h5);

      // stall holds the slot, release accepts and reloads on the same edge
      flush();
      push(0, 8'hA1);
      out_ready = 1'b0;
      tick();
      push(1, 8'hB2);
      repeat (5) begin
         tick();
         chk("t4_stall_read", 32'(last_read), 32'h0);
         chk("t4_hold_item", 32'(item4), 32'hA1);
         chk("t4_hold_port", 32'(port4), 32'h0);
      end
      out_ready = 1'b1;
      tick();
      chk("t4_reload_read", 32'(last_read), 32'h2);
      chk("t4_reload_valid", 32'(valid4), 32'h1);
      chk("t4_reload_item", 32'(item4), 32'hB2);
      chk("t4_reload_port", 32'(port4), 32'h1);

      // reset while holding a stalled item
      flush();
      push(3, 8'h7C);
      out_ready = 1'b0;
      tick();
      chk("t6_loaded", 32'(valid4), 32'h1);
      push(0, 8'h01);
      reset = 1'b0;
      tick();
      chk("t6_read_in_reset", 32'(last_read), 32'h0);
      chk("t6_valid_cleared", 32'(valid4), 32'h0);
      reset = 1'b1;
      tick();
      chk("t6_grant_after", 32'(last_read), 32'h1);

      // PORTS=3 with a 2-bit index: wrap happens at 2, not 3
      sel = 3;
      flush();
      out_ready = 1'b1;
      push(1, 8'h11);
      tick();
      chk("t5_first_grant", 32'(last_read), 32'h2);
      tick();
      push(0, 8'h20);
      tick();
      chk("t5_wrap_grant", 32'(last_read), 32'h1);
      chk("t5_wrap_port", 32'(port3), 32'h0);
      chk("t5_wrap_item", 32'(item3), 32'h20);
      push(0, 8'h30);
      push(1, 8'h31);
      push(2, 8'h32);
      tick();
      chk("t5_ptr_after_wrap", 32'(last_read), 32'h2);

      // randomized traffic on both instances
      verbose = 1'b0;
      for (int s = 0; s < 2; s++) begin
         sel = (s == 0) ? 4 : 3;
         flush();
         for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < sel; p++) begin
               if (fq[p].size() < 4 && $urandom_range(0, 2) == 0) push(p, 8'($urandom));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 99) != 0);
            tick();
         end
         reset = 1'b1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
